// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The requester side drives req; the arbiter drives gnt, gnt_valid and state.
interface round_robin_arbiter_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          gnt_valid;
   logic [PW-1:0] state;

   modport master (
      output req,
      input  gnt,
      input  gnt_valid,
      input  state
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_valid,
      output state
   );
endinterface

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with a registered one-hot grant.
// The priority pointer moves to one past the last winner, so that winner has lowest priority next.
module round_robin_arbiter #(
   parameter int unsigned N  = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   round_robin_arbiter_if.slave bus
);

   logic [N-1:0]  gnt_q, gnt_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] ptr_q, ptr_d;

   int unsigned idx;

   // Search from the pointer upward with wrap; the first asserted request wins.
   always_comb begin
      gnt_d   = '0;
      valid_d = 1'b0;
      ptr_d   = ptr_q;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!valid_d && bus.req[idx]) begin
            valid_d    = 1'b1;
            gnt_d[idx] = 1'b1;
            ptr_d      = PW'((idx + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = valid_q;
   assign bus.state     = ptr_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed plan steps, then random traffic with mid-cycle resets,
// checked against a priority-list model of the arbiter.
module tb_round_robin_arbiter;
   localparam int N  = 4;
   localparam int PW = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;

   round_robin_arbiter_if #(.N(N)) bus ();

   round_robin_arbiter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: priority order kept as a list; after a grant it rotates until the winner sits last.
   int             prio[$];
   logic [N-1:0]   exp_gnt;
   logic           exp_valid;
   logic [PW-1:0]  exp_state;

   task automatic model_reset();
      prio.delete();
      for (int i = 0; i < N; i++) prio.push_back(i);
      exp_gnt   = '0;
      exp_valid = 1'b0;
      exp_state = '0;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      int w;
      w = -1;
      foreach (prio[k]) if (w < 0 && r[prio[k]]) w = prio[k];
      exp_gnt = '0;
      if (w < 0) begin
         exp_valid = 1'b0;
      end else begin
         exp_gnt[w] = 1'b1;
         exp_valid  = 1'b1;
         while (prio[N-1] != w) prio.push_back(prio.pop_front());
      end
      exp_state = PW'(prio[0]);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".gnt"},    32'(bus.gnt),       32'(exp_gnt));
      chk({tag, ".valid"},  32'(bus.gnt_valid), 32'(exp_valid));
      chk({tag, ".state"},  32'(bus.state),     32'(exp_state));
      chk({tag, ".onehot"}, 32'($countones(bus.gnt) <= 1), 32'(1));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".gnt"},   32'(bus.gnt),       32'(0));
      chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(0));
      chk({tag, ".state"}, 32'(bus.state),     32'(0));
   endtask

   // Drive req just after an edge, let one edge sample it, compare 1 time unit later.
   task automatic apply(input logic [N-1:0] r, input string tag);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
      chk_outputs(tag);
   endtask

   // Assert reset between edges and confirm it acts without a clock edge.
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_zero({tag, ".async"});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus.req = 4'b1111;
      model_reset();

      #1;
      chk_zero("reset_t1");
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_zero("reset_held");
      end
      @(negedge clk);
      rst_n = 1'b1;

      apply(4'b1111, "release");
      chk("release.gnt_const",   32'(bus.gnt),   32'(4'b0001));
      chk("release.state_const", 32'(bus.state), 32'(1));

      repeat (3) apply(4'b0000, "idle");
      chk("idle.state_const", 32'(bus.state), 32'(1));
      apply(4'b0001, "first_req");
      chk("first_req.gnt_const", 32'(bus.gnt), 32'(4'b0001));

      mid_reset("pre_rot");
      for (int i = 0; i < 8; i++) begin
         apply(4'b1111, "rotate");
         chk("rotate.gnt_const", 32'(bus.gnt), 32'(1 << (i % 4)));
      end
      apply(4'b1111, "rotate_more");
      apply(4'b1111, "rotate_more");
      mid_reset("mid_stream");

      apply(4'b0100, "to_state3");
      chk("to_state3.state_const", 32'(bus.state), 32'(3));
      apply(4'b0110, "skip_wrap");
      chk("skip_wrap.gnt_const",   32'(bus.gnt),   32'(4'b0010));
      chk("skip_wrap.state_const", 32'(bus.state), 32'(2));
      apply(4'b0110, "skip_next");
      chk("skip_next.gnt_const",   32'(bus.gnt),   32'(4'b0100));
      chk("skip_next.state_const", 32'(bus.state), 32'(3));

      for (int i = 0; i < 3; i++) begin
         apply(4'b1000, "sole");
         chk("sole.gnt_const",   32'(bus.gnt),   32'(4'b1000));
         chk("sole.state_const", 32'(bus.state), 32'(0));
      end

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) mid_reset("rand_reset");
         apply(4'($urandom_range(0, 15)), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- N-requester round-robin arbiter with a registered one-hot grant and a rotating priority pointer.
- Sits in front of a shared resource (bus, memory port, output queue) where requesters drive level-sensitive request lines.
- Guarantees starvation-free service: the most recently granted requester gets lowest priority in the next arbitration.

Parameters:
- N, 4, number of requesters (N >= 2).
- PW, $clog2(N), width of the priority pointer (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource; level-sensitive, sampled each rising edge.
- state  output  PW  current priority pointer; the index with highest priority in the next arbitration.
- gnt  output  N  registered one-hot grant; all-zero when nothing granted.
- gnt_valid  output  1  high when gnt is non-zero (exactly one bit set).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n = 0, gnt = 0, gnt_valid = 0, state = 0, regardless of clk. Deassertion takes effect at the next rising edge.
- Arbitration is combinational from req and state. Results are registered, giving a 1-cycle latency: req sampled at edge k appears on gnt/gnt_valid after edge k.
- Search order: state, state+1, ..., N-1, 0, ..., state-1 (mod N). The first index with req set wins.
- Winner i registers:
  - gnt = one-hot(i), gnt_valid = 1
  - state = (i+1) mod N; wraps from N-1 to 0.
- req = 0: gnt = 0, gnt_valid = 0, state holds its value.
- Re-arbitrates every cycle; there is no grant lock. A continuously requesting sole requester is granted every cycle, with the pointer rotating past it each time.
- A requester that drops req loses its grant at the next edge. No response is required from requesters.
- gnt is always one-hot or zero; never more than one bit set.
- gnt_valid is exactly the reduction-OR of gnt and is registered alongside it.
- Fairness: with all N requests held high, grants cycle 0,1,...,N-1,0,...; each requester is served exactly once per N cycles.
- Reset asserted mid-operation immediately clears gnt, gnt_valid and state. The first arbitration after release starts from index 0.
- X/Z on req is not handled specially; the bench shall drive known values.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 and toggling clk -> gnt=4'b0000, gnt_valid=0, state=0 throughout. Release rst_n -> one edge later gnt=4'b0001, state=1.
- Idle/valid: req=4'b0000 for 3 cycles -> gnt=0, gnt_valid=0, state unchanged. Then req=4'b0001 -> after next edge gnt=4'b0001, gnt_valid=1, state=1.
- Rotation: req=4'b1111 held 8 cycles from state=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; gnt_valid=1 every cycle.
- Skip/wrap: state=3, req=4'b0110 -> gnt=4'b0010, state=2. Next cycle req unchanged -> gnt=4'b0100, state=3.
- Single persistent requester: req=4'b1000 for 3 cycles -> gnt=4'b1000 each cycle, state=0 after each grant.
- Async reset mid-stream: assert rst_n=0 between edges during rotation -> gnt, gnt_valid, state go to 0 immediately, without waiting for a clock edge.
